// File: rtl/adc_spi_master_if.sv
// Command/response bus of the ADC register-access SPI master.
// The host drives commands (master side); adc_spi_master answers (slave side).
interface adc_spi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/adc_spi_master.sv
// Register-access SPI master for the 3-wire ADC: one 24-bit frame
// {rw, 2'b00, addr[12:0], data[7:0]} per command, MSB first, SPI mode 0.
// Every output comes straight from a flop; all timing is driven by one
// down-counter that fires an event when it reaches zero.
module adc_spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    adc_spi_master_if.slave   bus,
    output logic              spi_en,
    output logic              sck,
    output logic              csn,
    output logic              mosi,
    input  logic              adc_miso
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        spi_en_q;
    logic        sck_q, sck_d;
    logic        csn_q, csn_d;
    logic        mosi_q, mosi_d;

    // Next-state and registered-output logic; a zero timer marks an event edge.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        sck_d       = sck_q;
        csn_d       = csn_q;
        mosi_d      = mosi_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (bus.cmd_valid && cmd_ready_q) begin
                    tx_d        = {bus.cmd_rw, 2'b00, bus.cmd_addr,
                                   bus.cmd_rw ? 8'h00 : bus.cmd_wdata};
                    rw_d        = bus.cmd_rw;
                    bit_d       = 5'd0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                // First SETUP edge drops csn; the timer then covers the setup time.
                if (csn_q) begin
                    csn_d  = 1'b0;
                    mosi_d = tx_q[23];
                    tmr_d  = 16'(CS_SETUP - 1);
                end else if (tmr_q == 16'd0) begin
                    state_d = StShift;
                    tmr_d   = 16'(CLK_DIV - 1);
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            StShift: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else begin
                    tmr_d = 16'(CLK_DIV - 1);
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], adc_miso};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 5'd23) begin
                            state_d = StHold;
                            tmr_d   = 16'(CS_HOLD - 1);
                        end else begin
                            bit_d  = bit_q + 5'd1;
                            tx_d   = {tx_q[22:0], 1'b0};
                            mosi_d = tx_q[22];
                        end
                    end
                end
            end
            StHold: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else begin
                    csn_d       = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rw_q ? rx_q : 8'h00;
                    state_d     = StGap;
                    tmr_d       = 16'(CS_GAP - 1);
                end
            end
            StGap: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            tmr_q       <= 16'd0;
            bit_q       <= 5'd0;
            tx_q        <= 24'd0;
            rx_q        <= 8'd0;
            rw_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            spi_en_q    <= 1'b0;
            sck_q       <= 1'b0;
            csn_q       <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            spi_en_q    <= 1'b1;
            sck_q       <= sck_d;
            csn_q       <= csn_d;
            mosi_q      <= mosi_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign spi_en        = spi_en_q;
    assign sck           = sck_q;
    assign csn           = csn_q;
    assign mosi          = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Self-checking bench for adc_spi_master: table and random frames against a
// frame-level reference model, plus back-to-back, busy-poke, mid-frame reset
// and a reduced-timing instance.
module tb_adc_spi_master;

    typedef struct {
        logic        rw;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  reply;
        logic [23:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    logic spi_en, sck, csn, mosi, adc_miso;
    logic spi_en2, sck2, csn2, mosi2, miso2;

    int nchecks = 0;
    int nerr    = 0;

    adc_spi_master_if bus ();
    adc_spi_master_if bus2 ();

    adc_spi_master dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .spi_en   (spi_en),
        .sck      (sck),
        .csn      (csn),
        .mosi     (mosi),
        .adc_miso (adc_miso)
    );

    adc_spi_master #(
        .CLK_DIV  (2),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_GAP   (2)
    ) dut2 (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus2),
        .spi_en   (spi_en2),
        .sck      (sck2),
        .csn      (csn2),
        .mosi     (mosi2),
        .adc_miso (miso2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the frame the ADC must see and the byte the host must get back.
    function automatic logic [23:0] model_frame(input logic rw, input logic [12:0] addr,
                                                input logic [7:0] wd);
        return {rw, 2'b00, addr, rw ? 8'h00 : wd};
    endfunction

    function automatic logic [7:0] model_rdata(input logic rw, input logic [7:0] reply);
        return rw ? reply : 8'h00;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    // One complete frame with an ADC model answering after 16 rises.
    task automatic run_frame(input vec_t v, input bit poke);
        int          rises = 0, csn_low = 0, rsp_t = -1, rsp_n = 0, ready_t = -1;
        logic [23:0] word = 24'd0;
        logic [7:0]  sh = v.reply;
        logic [7:0]  rd_at_rsp = 8'h00;
        logic        csn_at_rsp = 1'b0;
        logic        prev_sck = 1'b0;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = v.rw;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        adc_miso      = 1'b0;
        @(negedge clk);
        // Scramble fields after accept; the frame in flight must not change.
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = ~v.rw;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        check("accept_state", 32'({bus.busy, bus.cmd_ready, csn}), 32'b101);
        for (int t = 1; t <= 400 && ready_t < 0; t++) begin
            @(negedge clk);
            bus.cmd_valid = poke && (t == 50);
            if (!csn) csn_low++;
            if (sck && !prev_sck) begin
                rises++;
                word = {word[22:0], mosi};
                if (rises >= 16 && rises < 24) begin
                    adc_miso = sh[7];
                    sh = {sh[6:0], 1'b0};
                end else begin
                    adc_miso = 1'b0;
                end
            end
            prev_sck = sck;
            if (bus.rsp_valid) begin
                rsp_n++;
                if (rsp_t < 0) begin
                    rsp_t      = t;
                    rd_at_rsp  = bus.rsp_rdata;
                    csn_at_rsp = csn;
                end
            end
            if (bus.cmd_ready) ready_t = t;
        end
        bus.cmd_valid = 1'b0;
        check("frame_bits", 32'(word), 32'(v.exp_frame));
        check("sck_rises", 32'(rises), 32'd24);
        check("csn_low_cycles", 32'(csn_low), 32'd196);
        check("rsp_latency", 32'(rsp_t), 32'd197);
        check("rsp_pulses", 32'(rsp_n), 32'd1);
        check("rsp_rdata", 32'(rd_at_rsp), 32'(v.exp_rdata));
        check("csn_high_at_rsp", 32'(csn_at_rsp), 32'd1);
        check("ready_latency", 32'(ready_t), 32'd199);
        repeat (5) @(negedge clk);
        check("idle_after_frame", 32'({csn, sck, bus.cmd_ready, bus.busy}), 32'b1010);
        check("rdata_held", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    endtask

    vec_t tbl[4];
    vec_t rv;

    initial begin
        int rises, rise_t, ready_t, high_n, lat, rsp_n;
        logic prev, fell;
        logic [23:0] word2;

        tbl[0] = '{rw: 1'b0, addr: 13'h0014, wdata: 8'hA5, reply: 8'h00,
                   exp_frame: 24'h0014A5, exp_rdata: 8'h00};
        tbl[1] = '{rw: 1'b1, addr: 13'h0001, wdata: 8'h77, reply: 8'h3C,
                   exp_frame: 24'h800100, exp_rdata: 8'h3C};
        tbl[2] = '{rw: 1'b1, addr: 13'h1FFF, wdata: 8'h00, reply: 8'hFF,
                   exp_frame: 24'h9FFF00, exp_rdata: 8'hFF};
        tbl[3] = '{rw: 1'b0, addr: 13'h1A5A, wdata: 8'h81, reply: 8'hFF,
                   exp_frame: 24'h1A5A81, exp_rdata: 8'h00};

        rst = 1'b1;
        adc_miso = 1'b0;
        miso2 = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus2.cmd_valid = 1'b0; bus2.cmd_rw = 1'b0; bus2.cmd_addr = '0; bus2.cmd_wdata = '0;

        // Reset values
        @(negedge clk);
        check("reset_outputs",
              32'({bus.cmd_ready, bus.rsp_valid, bus.busy, spi_en, sck, csn, mosi}),
              32'b0000010);
        check("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'({bus.cmd_ready, spi_en}), 32'b11);

        // Reduced-timing instance: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1
        bus2.cmd_valid = 1'b1; bus2.cmd_rw = 1'b0;
        bus2.cmd_addr = 13'h0014; bus2.cmd_wdata = 8'hA5;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        rises = 0; lat = -1; prev = 1'b0; word2 = 24'd0;
        for (int t = 1; t <= 200 && lat < 0; t++) begin
            @(negedge clk);
            if (sck2 && !prev) begin
                rises++;
                word2 = {word2[22:0], mosi2};
            end
            prev = sck2;
            if (bus2.rsp_valid) lat = t;
        end
        check("fast_latency", 32'(lat), 32'd99);
        check("fast_rises", 32'(rises), 32'd24);
        check("fast_frame", 32'(word2), 32'(model_frame(1'b0, 13'h0014, 8'hA5)));

        // Table vectors (entry 1 also pokes cmd_valid while busy)
        for (int i = 0; i < 4; i++) run_frame(tbl[i], i == 1);

        // Random frames against the reference model
        for (int i = 0; i < 6; i++) begin
            rv.rw        = 1'($urandom_range(0, 1));
            rv.addr      = 13'($urandom_range(0, 8191));
            rv.wdata     = 8'($urandom_range(0, 255));
            rv.reply     = 8'($urandom_range(0, 255));
            rv.exp_frame = model_frame(rv.rw, rv.addr, rv.wdata);
            rv.exp_rdata = model_rdata(rv.rw, rv.reply);
            run_frame(rv, 1'b0);
        end

        // Back-to-back with cmd_valid held high
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = 13'h0123; bus.cmd_wdata = 8'h5A;
        @(negedge clk);
        bus.cmd_addr = 13'h0456; bus.cmd_wdata = 8'hC3;
        rise_t = -1; ready_t = -1; high_n = 0; prev = csn;
        for (int t = 1; t <= 400 && ready_t < 0; t++) begin
            @(negedge clk);
            if (csn && !prev && rise_t < 0) rise_t = t;
            if (csn && rise_t >= 0) high_n++;
            prev = csn;
            if (bus.cmd_ready) ready_t = t;
        end
        check("b2b_accept_after_csn_rise", 32'(ready_t - rise_t), 32'd2);
        @(negedge clk);
        check("b2b_second_accepted", 32'({bus.cmd_ready, bus.busy}), 32'b01);
        bus.cmd_valid = 1'b0;
        if (csn) high_n++;
        fell = 1'b0; lat = -1;
        for (int t = 1; t <= 300 && lat < 0; t++) begin
            @(negedge clk);
            if (!fell && csn) high_n++;
            if (!csn) fell = 1'b1;
            if (bus.rsp_valid) lat = t;
        end
        check("b2b_csn_gap_min", 32'(high_n >= 2), 32'd1);
        check("b2b_second_latency", 32'(lat), 32'd197);
        repeat (3) @(negedge clk);

        // Reset at sck rise 10
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = 13'h00AA; bus.cmd_wdata = 8'h33;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rises = 0; prev = 1'b0; rsp_n = 0;
        for (int t = 1; t <= 200 && rises < 10; t++) begin
            @(negedge clk);
            if (sck && !prev) rises++;
            prev = sck;
        end
        check("rises_before_reset", 32'(rises), 32'd10);
        rst = 1'b1;
        #1;
        check("reset_mid_frame",
              32'({csn, sck, mosi, spi_en, bus.cmd_ready, bus.busy}), 32'b100000);
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_1clk_after_reset", 32'({bus.cmd_ready, spi_en}), 32'b11);
        repeat (5) begin
            if (bus.rsp_valid) rsp_n++;
            @(negedge clk);
        end
        check("no_rsp_after_abort", 32'(rsp_n), 32'd0);
        run_frame(tbl[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
